// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus master: FSM states, default
// widths and the register map offsets of the attached peripheral block.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  localparam logic [7:0] REG_TIME      = 8'h00;
  localparam logic [7:0] REG_PRESCALER = 8'h04;
  localparam logic [7:0] REG_IENABLE   = 8'h08;
  localparam logic [7:0] REG_IPENDING  = 8'h0C;
  localparam logic [7:0] REG_TIMECMP0  = 8'h10;

endpackage

// File: rtl/periph_bus_master.sv
// Single-outstanding peripheral bus master. A host request is latched in
// IDLE, driven onto the peripheral bus for the whole ACCESS phase until the
// responder signals ready (or the wait budget expires), and reported back as
// a one-cycle response strobe in RESP.
module periph_bus_master
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              cs,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ready,
  input  logic              error
);

  // A zero TIMEOUT still needs a one-bit counter to keep widths legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_timeout;
  logic                w_accept;
  logic                w_done;
  logic                w_timeout;

  // Next-state and bus/handshake outputs; ready wins over an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    cs          = 1'b0;
    rw          = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cs = 1'b1;
        rw = r_we;
        if (ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if ((TIMEOUT > 0) && (r_cnt == CNT_LAST)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Request latch; these values stay on addr/wdata after the access ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Saturating wait-cycle counter, cleared on every new access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !ready && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Response registers, held until the next completion or timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_done) begin
      r_rsp_rdata   <= (r_we || error) ? '0 : rdata;
      r_rsp_err     <= error;
      r_rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b1;
      r_rsp_timeout <= 1'b1;
    end
  end

  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: doc/periph_bus_master.md
PERIPH_BUS_MASTER -- requirements
Module: periph_bus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, peripheral address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort; 0 disables timeout.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  host request present.
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  target register address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes, errors and timeouts.
REQ-013 SHALL have port rsp_err  output  1  responder error or timeout.
REQ-014 SHALL have port rsp_timeout  output  1  transfer aborted by timeout.
REQ-015 SHALL have ports cs  output  1, addr  output  ADDR_W, rw  output  1, wdata  output  DATA_W: peripheral bus drive.
REQ-016 SHALL have ports rdata  input  DATA_W, ready  input  1, error  input  1: peripheral bus return.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 IDLE: req_ready=1, cs=0, rw=0; on req_valid, latch we/addr/wdata and go ACCESS next cycle.
REQ-019 ACCESS: cs=1, rw=latched we, addr/wdata=latched values, constant for the whole state; req_ready=0.
REQ-020 ACCESS: when ready=1, sample rdata (reads only) and error into response registers and go RESP; cs SHALL deassert the following cycle so a write lands exactly once.
REQ-021 ACCESS: wait counter starts at 0 on entry, increments each cycle ready=0; when counter equals TIMEOUT-1 with ready=0 (TIMEOUT>0), go RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-022 ready=1 in the final timeout cycle SHALL take priority: normal completion, no timeout.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, req_ready=0, cs=0; return to IDLE.
REQ-024 rsp_rdata/rsp_err/rsp_timeout SHALL hold their values until the next RESP.
REQ-025 Latency with zero-wait responder: request accepted cycle N, cs high cycle N+1, rsp_valid cycle N+2; max 3 cycles per transfer.
REQ-026 rsp_err = sampled error OR timeout; a write with error=1 SHALL still report rsp_rdata=0.
REQ-027 Requests presented outside IDLE SHALL be ignored (req_ready=0); host must hold them.
REQ-028 Wait counter width SHALL be clog2(TIMEOUT+1), saturating, never wrapping.
REQ-029 When cs=0, addr and wdata SHALL hold last latched values; rw SHALL be 0.

Reset
REQ-030 rst=0 at a clock edge SHALL force IDLE, counter 0, cs=0, rw=0, addr=0, wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, req_ready=1 after that edge.
REQ-031 Reset during ACCESS SHALL abort the transfer with no response strobe; cs low after the reset edge.

Structure
REQ-032 Shared package periph_bus_pkg SHALL hold the state enum, default ADDR_W/DATA_W, and bus register offset constants (TIME 0x00, PRESCALER 0x04, IENABLE 0x08, IPENDING 0x0C, TIMECMP0 0x10).
REQ-033 Single module, no sub-modules.

Verification
REQ-034 Write 0x05 to 0x04, ready tied 1 -> cs high exactly 1 cycle with rw=1, wdata=0x05; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-035 Read 0x08, responder returns rdata=0x7 with ready=1 -> rsp_rdata=0x7, rsp_err=0, rsp_timeout=0.
REQ-036 Read 0x84, responder asserts error=1 with ready -> rsp_err=1, rsp_rdata=0, rsp_timeout=0.
REQ-037 TIMEOUT=16, ready held 0 -> cs high 16 cycles, then rsp_valid with rsp_err=1, rsp_timeout=1; ready asserted in 16th cycle instead -> normal completion.
REQ-038 rst=0 on 3rd ACCESS cycle of a waited read -> cs low next cycle, no rsp_valid, next request completes normally.
